// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM states and response codes for the load/store unit
package lsu_pkg;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    localparam logic [1:0] RSP_OK       = 2'b00;
    localparam logic [1:0] RSP_MISALIGN = 2'b01;
    localparam logic [1:0] RSP_ILLEGAL  = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT  = 2'b11;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane extraction/extension for loads and lane merge plus byte enables for stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] load_val,
    output logic [31:0] store_word,
    output logic [3:0]  be
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] rep;
    always_comb begin
        b = old_word[{addr, 3'b000} +: 8];
        h = addr[1] ? old_word[31:16] : old_word[15:0];
        load_val = funct3 == LB  ? {{24{b[7]}}, b} :
                   funct3 == LBU ? {24'h0, b} :
                   funct3 == LH  ? {{16{h[15]}}, h} :
                   funct3 == LHU ? {16'h0, h} : old_word;
        be = funct3[1:0] == 2'b00 ? 4'b0001 << addr :
             funct3[1:0] == 2'b01 ? 4'b0011 << addr : 4'hF;
        // replicate the store data across lanes so the enabled lanes pick it up in place
        rep = funct3[1:0] == 2'b00 ? {4{new_data[7:0]}} :
              funct3[1:0] == 2'b01 ? {2{new_data[15:0]}} : new_data;
        for (int i = 0; i < 4; i++) store_word[8*i +: 8] = be[i] ? rep[8*i +: 8] : old_word[8*i +: 8];
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle RV32I load/store unit with RMW sub-word stores, error checks and ack timeout
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter bit HAS_BE  = 1'b0,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [1:0]        rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q, old_q, align_old, load_val, store_word;
    logic [3:0]        lane_be;
    logic [CW-1:0]     cnt;
    logic              legal, misal, go_rd, expired;
    always_comb begin
        legal = req_we ? (req_funct3 == SB || req_funct3 == SH || req_funct3 == SW)
                       : (req_funct3 == LB || req_funct3 == LH || req_funct3 == LW ||
                          req_funct3 == LBU || req_funct3 == LHU);
        misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        go_rd = !req_we || (!HAS_BE && req_funct3 != SW);
    end
    // loads extend straight from the bus; RMW merges against the word captured in RD
    assign align_old = state == RD ? mem_rdata : (HAS_BE ? 32'h0 : old_q);
    lsu_lane_align u_align (
        .funct3    (f3_q),
        .addr      (addr_q[1:0]),
        .old_word  (align_old),
        .new_data  (wdata_q),
        .load_val  (load_val),
        .store_word(store_word),
        .be        (lane_be)
    );
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign mem_req   = state == RD || state == WR;
    assign mem_we    = state == WR;
    assign mem_addr  = mem_req ? addr_q[ADDR_W+1:2] : '0;
    assign mem_be    = !mem_req ? 4'h0 : (HAS_BE && mem_we) ? lane_be : 4'hF;
    assign mem_wdata = mem_we ? store_word : 32'h0;
    assign expired   = cnt == CW'(TIMEOUT);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            old_q     <= 32'h0;
            cnt       <= '0;
            rsp_err   <= RSP_OK;
            rsp_rdata <= 32'h0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q      <= req_we;
                    f3_q      <= req_funct3;
                    addr_q    <= req_addr[ADDR_W+1:0];
                    wdata_q   <= req_wdata;
                    cnt       <= '0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= !legal ? RSP_ILLEGAL : misal ? RSP_MISALIGN : RSP_OK;
                    state     <= (!legal || misal) ? RESP : go_rd ? RD : WR;
                end
                RD, WR: if (mem_ack) begin
                    cnt <= '0;
                    if (state == WR) state <= RESP;
                    else if (we_q) begin
                        old_q <= mem_rdata;
                        state <= WR;
                    end else begin
                        rsp_rdata <= load_val;
                        state     <= RESP;
                    end
                end else if (expired) begin
                    rsp_err <= RSP_TIMEOUT;
                    state   <= RESP;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench driving a byte-enable-less and a byte-enable instance of the unit
module tb_mem_access_unit;
    typedef struct {int inst; logic [1:0] err; logic [31:0] rdata; int lat;} rsp_t;
    typedef struct {int inst; logic [7:0] addr; logic [31:0] data; logic [3:0] be;} wr_t;
    localparam int TO = 15;
    logic        clk = 1'b0, rstn = 1'b1;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  vld = 2'b00, rdy, mreq;
    int          dly = 0;
    logic        withhold = 1'b0;
    int          checks = 0, failures = 0;
    int          reads[2], last_len[2], addr_chg[2], req_seen[2];
    rsp_t        exp_q[$];
    wr_t         wr_q[$];
    always #5 clk = ~clk;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    for (genvar g = 0; g < 2; g++) begin : gi
        logic        req_ready, rsp_valid, mem_req, mem_we, mem_ack;
        logic [1:0]  rsp_err;
        logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
        logic [7:0]  mem_addr, prev = 8'h0;
        logic [3:0]  mem_be;
        logic [31:0] mem [256];
        int          wcnt = 0, cur = 0, ncyc = 0, acc = 0;
        rsp_t        r;
        wr_t         w;
        mem_access_unit #(.ADDR_W(8), .HAS_BE(g), .TIMEOUT(TO)) dut (
            .clk(clk), .rstn(rstn), .req_valid(vld[g]), .req_ready(req_ready), .req_we(req_we),
            .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
            .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mem_req(mem_req), .mem_we(mem_we),
            .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
            .mem_rdata(mem_rdata)
        );
        assign rdy[g]    = req_ready;
        assign mreq[g]   = mem_req;
        assign mem_ack   = mem_req && !withhold && wcnt >= dly;
        assign mem_rdata = mem[mem_addr];
        initial begin
            reads[g] = 0; last_len[g] = 0; addr_chg[g] = 0; req_seen[g] = 0;
        end
        always @(posedge clk) begin
            wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
            if (mem_req && mem_we && mem_ack)
                for (int b = 0; b < 4; b++) if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        always @(negedge clk) begin
            ncyc++;
            if (vld[g] && req_ready) acc = ncyc;
            if (mem_req) begin
                req_seen[g]++;
                if (cur != 0 && mem_addr != prev) addr_chg[g]++;
                prev = mem_addr;
                cur++;
            end else if (cur != 0) begin
                last_len[g] = cur;
                cur = 0;
            end
            if (mem_req && !mem_we && mem_ack) reads[g]++;
            if (mem_req && mem_we && mem_ack) begin
                if (wr_q.size() == 0) check("unexpected_write", {24'h0, mem_addr}, 32'hFFFF_FFFF);
                else begin
                    w = wr_q.pop_front();
                    check("wr_inst", g, w.inst);
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                    check("wr_be", mem_be, w.be);
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("unexpected_rsp", rsp_err, 32'hFFFF_FFFF);
                else begin
                    r = exp_q.pop_front();
                    check("rsp_inst", g, r.inst);
                    check("rsp_err", rsp_err, r.err);
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("rsp_latency", ncyc - acc, r.lat);
                end
            end
        end
    end
    task automatic issue(int k, logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, bit wait_done);
        int n = 0;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; vld[k] = 1'b1;
        @(posedge clk); #1;
        vld[k] = 1'b0;
        if (wait_done) begin
            while (!rdy[k] && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            check("return_idle", rdy[k], 1);
            @(posedge clk); #1;
        end
    endtask
    task automatic ld(int k, logic [2:0] f3, logic [31:0] a, logic [1:0] err, logic [31:0] rd, int lat);
        exp_q.push_back('{k, err, rd, lat});
        issue(k, 1'b0, f3, a, 32'h0, 1'b1);
    endtask
    task automatic st(int k, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [1:0] err, int lat,
                      bit wr, logic [31:0] wdat, logic [3:0] be);
        exp_q.push_back('{k, err, 32'h0, lat});
        if (wr) wr_q.push_back('{k, a[9:2], wdat, be});
        issue(k, 1'b1, f3, a, wd, 1'b1);
    endtask
    initial begin
        int s, rc;
        #1 rstn = 1'b0;
        #5;
        check("rst_ready", rdy[0], 1);
        check("rst_rsp_valid", gi[0].rsp_valid, 0);
        check("rst_mem_req", mreq[0], 0);
        check("rst_mem_we", gi[0].mem_we, 0);
        check("rst_err", gi[0].rsp_err, 0);
        check("rst_rdata", gi[0].rsp_rdata, 0);
        check("rst_addr", gi[0].mem_addr, 0);
        check("rst_be", gi[1].mem_be, 0);
        check("rst_wdata", gi[0].mem_wdata, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        rc = reads[0];
        st(0, 3'b010, 32'h10, 32'h80FF_1234, 2'b00, 2, 1, 32'h80FF_1234, 4'hF);
        check("sw_no_read", reads[0] - rc, 0);
        ld(0, 3'b000, 32'h13, 2'b00, 32'hFFFF_FF80, 2);
        ld(0, 3'b101, 32'h12, 2'b00, 32'h0000_80FF, 2);
        ld(0, 3'b001, 32'h12, 2'b00, 32'hFFFF_80FF, 2);
        ld(0, 3'b100, 32'h11, 2'b00, 32'h0000_0012, 2);
        s = req_seen[0];
        ld(0, 3'b010, 32'h11, 2'b01, 32'h0, 1);
        ld(0, 3'b001, 32'h13, 2'b01, 32'h0, 1);
        check("misalign_no_req", req_seen[0] - s, 0);
        st(0, 3'b010, 32'h10, 32'h1122_3344, 2'b00, 2, 1, 32'h1122_3344, 4'hF);
        rc = reads[0];
        st(0, 3'b000, 32'h11, 32'h0000_00AA, 2'b00, 3, 1, 32'h1122_AA44, 4'hF);
        check("rmw_one_read", reads[0] - rc, 1);
        st(0, 3'b001, 32'h12, 32'h0000_BEEF, 2'b00, 3, 1, 32'hBEEF_AA44, 4'hF);
        ld(0, 3'b010, 32'h10, 2'b00, 32'hBEEF_AA44, 2);
        check("rdata_held", gi[0].rsp_rdata, 32'hBEEF_AA44);
        ld(0, 3'b010, 32'h410, 2'b00, 32'hBEEF_AA44, 2);
        s = req_seen[0];
        st(0, 3'b011, 32'h11, 32'h0, 2'b10, 1, 0, 32'h0, 4'h0);
        st(0, 3'b100, 32'h10, 32'h0, 2'b10, 1, 0, 32'h0, 4'h0);
        ld(0, 3'b110, 32'h11, 2'b10, 32'h0, 1);
        check("illegal_no_req", req_seen[0] - s, 0);
        dly = 3;
        ld(0, 3'b010, 32'h10, 2'b00, 32'hBEEF_AA44, 5);
        check("wait_req_len", last_len[0], 4);
        dly = 0;
        withhold = 1'b1;
        ld(0, 3'b010, 32'h10, 2'b11, 32'h0, TO + 2);
        check("timeout_req_len", last_len[0], TO + 1);
        rc = reads[0];
        st(0, 3'b000, 32'h11, 32'h55, 2'b11, TO + 2, 0, 32'h0, 4'h0);
        check("rmw_timeout_no_read", reads[0] - rc, 0);
        withhold = 1'b0;
        rc = reads[1];
        st(1, 3'b001, 32'h16, 32'h0000_BEEF, 2'b00, 2, 1, 32'hBEEF_0000, 4'b1100);
        st(1, 3'b000, 32'h13, 32'h0000_005A, 2'b00, 2, 1, 32'h5A00_0000, 4'b1000);
        check("be_no_read", reads[1] - rc, 0);
        st(1, 3'b010, 32'h10, 32'h1234_5678, 2'b00, 2, 1, 32'h1234_5678, 4'hF);
        ld(1, 3'b000, 32'h13, 2'b00, 32'h0000_0012, 2);
        withhold = 1'b1;
        issue(0, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_wr_req", mreq[0], 1);
        check("mid_wr_we", gi[0].mem_we, 1);
        rstn = 1'b0;
        #1;
        check("abort_req_drop", mreq[0], 0);
        @(posedge clk); #1 rstn = 1'b1;
        withhold = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", rdy[0], 1);
        repeat (3) @(posedge clk);
        #1;
        check("rsp_queue_empty", exp_q.size(), 0);
        check("wr_queue_empty", wr_q.size(), 0);
        check("addr_stable", addr_chg[0] + addr_chg[1], 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
